// File: rtl/exec_sequencer.sv
// ============================================================================
// Module      : exec_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB/INT phase controller for
//               the 18-bit stack CPU, with interrupt enable and retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_sequencer #(
   parameter int DMEM_TIMEOUT = 8,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_dmem_ren,
   input  logic             dec_dmem_wen,
   input  logic             dec_pmem_wen,
   input  logic             dec_set_ien,
   input  logic             dec_clear_ien,
   input  logic             irq,
   input  logic             dmem_ack,
   output logic             imem_ren,
   output logic             ir_load,
   output logic             exec_en,
   output logic             pmem_we,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             wb_en,
   output logic             int_take,
   output logic             ien,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       phase
);

   localparam int TO_W = (DMEM_TIMEOUT > 2) ? $clog2(DMEM_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(DMEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_INT    = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [TO_W-1:0]  r_tocnt;
   logic             r_ien;
   logic             r_bus_err;
   logic [CNT_W-1:0] r_instret;

   logic w_mem_op;
   logic w_new_ien;
   logic w_retire;
   logic w_timeout;
   logic w_imem_ren, w_ir_load, w_exec_en, w_pmem_we;
   logic w_dmem_req, w_dmem_we, w_wb_en, w_int_take;

   assign w_mem_op  = dec_dmem_ren | dec_dmem_wen;
   // Clear has priority over set when an instruction asserts both.
   assign w_new_ien = dec_clear_ien ? 1'b0 : (dec_set_ien ? 1'b1 : r_ien);

   always_comb begin
      w_next     = r_state;
      w_retire   = 1'b0;
      w_timeout  = 1'b0;
      w_imem_ren = 1'b0;
      w_ir_load  = 1'b0;
      w_exec_en  = 1'b0;
      w_pmem_we  = 1'b0;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      w_wb_en    = 1'b0;
      w_int_take = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_imem_ren = 1'b1;
            w_next     = S_DECODE;
         end
         S_DECODE: begin
            w_ir_load = 1'b1;
            w_next    = S_EXEC;
         end
         S_EXEC: begin
            if (w_mem_op) begin
               w_next = S_MEM;
            end else begin
               w_exec_en = 1'b1;
               w_pmem_we = dec_pmem_wen;
               w_retire  = 1'b1;
               w_next    = (irq && w_new_ien) ? S_INT : S_FETCH;
            end
         end
         S_MEM: begin
            w_dmem_req = 1'b1;
            w_dmem_we  = dec_dmem_wen;
            // An ack arriving on the final allowed cycle still completes.
            if (dmem_ack) begin
               w_next = S_WB;
            end else if (r_tocnt == c_TO_LAST) begin
               w_timeout = 1'b1;
               w_next    = S_FETCH;
            end
         end
         S_WB: begin
            w_wb_en  = 1'b1;
            w_retire = 1'b1;
            w_next   = (irq && w_new_ien) ? S_INT : S_FETCH;
         end
         S_INT: begin
            w_int_take = 1'b1;
            w_next     = S_FETCH;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tocnt <= '0;
      end else if (r_state == S_MEM) begin
         if (dmem_ack || w_timeout) begin
            r_tocnt <= '0;
         end else begin
            r_tocnt <= r_tocnt + TO_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ien <= 1'b0;
      end else if (w_retire) begin
         r_ien <= w_new_ien;
      end else if (r_state == S_INT) begin
         r_ien <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus_err <= 1'b0;
         r_instret <= '0;
      end else begin
         if (w_timeout) begin
            r_bus_err <= 1'b1;
         end
         if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   // Strobes are forced low for the whole time reset is held.
   assign imem_ren = w_imem_ren & ~rst;
   assign ir_load  = w_ir_load  & ~rst;
   assign exec_en  = w_exec_en  & ~rst;
   assign pmem_we  = w_pmem_we  & ~rst;
   assign dmem_req = w_dmem_req & ~rst;
   assign dmem_we  = w_dmem_we  & ~rst;
   assign wb_en    = w_wb_en    & ~rst;
   assign int_take = w_int_take & ~rst;
   assign ien      = r_ien;
   assign bus_err  = r_bus_err;
   assign instret  = r_instret;
   assign phase    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_exec_sequencer.sv
// ============================================================================
// Module      : tb_exec_sequencer
// Description : Directed self-checking bench for exec_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_sequencer;

   localparam int DMEM_TIMEOUT = 8;
   localparam int CNT_W        = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             dec_dmem_ren = 1'b0;
   logic             dec_dmem_wen = 1'b0;
   logic             dec_pmem_wen = 1'b0;
   logic             dec_set_ien = 1'b0;
   logic             dec_clear_ien = 1'b0;
   logic             irq = 1'b0;
   logic             dmem_ack = 1'b0;
   logic             imem_ren, ir_load, exec_en, pmem_we;
   logic             dmem_req, dmem_we, wb_en, int_take;
   logic             ien, bus_err;
   logic [CNT_W-1:0] instret;
   logic [2:0]       phase;

   int               n_cmp = 0;
   int               n_err = 0;
   int               int_cnt = 0;
   logic [CNT_W-1:0] exp_instret = '0;

   exec_sequencer #(.DMEM_TIMEOUT(DMEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .dec_dmem_ren(dec_dmem_ren), .dec_dmem_wen(dec_dmem_wen),
      .dec_pmem_wen(dec_pmem_wen), .dec_set_ien(dec_set_ien),
      .dec_clear_ien(dec_clear_ien), .irq(irq), .dmem_ack(dmem_ack),
      .imem_ren(imem_ren), .ir_load(ir_load), .exec_en(exec_en),
      .pmem_we(pmem_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .wb_en(wb_en), .int_take(int_take), .ien(ien), .bus_err(bus_err),
      .instret(instret), .phase(phase)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (int_take) int_cnt++;
         n_cmp++;
         if ($countones({imem_ren, ir_load, exec_en, dmem_req, wb_en, int_take}) > 1) begin
            n_err++;
            $display("FAIL onehot: strobes %b, required at most one high",
                     {imem_ren, ir_load, exec_en, dmem_req, wb_en, int_take});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dec(input logic ren, input logic wen, input logic pwen,
                          input logic sien, input logic cien);
      dec_dmem_ren  = ren;
      dec_dmem_wen  = wen;
      dec_pmem_wen  = pwen;
      dec_set_ien   = sien;
      dec_clear_ien = cien;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      n_cmp++;
      if ({imem_ren, ir_load, exec_en, pmem_we, dmem_req, dmem_we, wb_en, int_take} !== 8'h00) begin
         n_err++;
         $display("FAIL reset_strobes: got %b required 00000000",
                  {imem_ren, ir_load, exec_en, pmem_we, dmem_req, dmem_we, wb_en, int_take});
      end
      n_cmp++;
      if ({phase, ien, bus_err} !== 5'b0 || instret !== '0) begin
         n_err++;
         $display("FAIL reset_state: phase %0d ien %b bus_err %b instret %0d required 0",
                  phase, ien, bus_err, instret);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (phase !== 3'd0 || imem_ren !== 1'b1) begin
         n_err++;
         $display("FAIL release_fetch: phase %0d imem_ren %b required 0/1", phase, imem_ren);
      end
   endtask

   task automatic test_alu();
      irq = 1'b0;
      set_dec(0, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if (phase !== 3'd1 || ir_load !== 1'b1) begin
         n_err++;
         $display("FAIL alu_decode: phase %0d ir_load %b required 1/1", phase, ir_load);
      end
      tick();
      n_cmp++;
      if (phase !== 3'd2 || exec_en !== 1'b1 || pmem_we !== 1'b0) begin
         n_err++;
         $display("FAIL alu_exec: phase %0d exec_en %b pmem_we %b required 2/1/0",
                  phase, exec_en, pmem_we);
      end
      tick();
      exp_instret++;
      n_cmp++;
      if (phase !== 3'd0 || exec_en !== 1'b0 || instret !== exp_instret) begin
         n_err++;
         $display("FAIL alu_retire: phase %0d exec_en %b instret %0d required 0/0/%0d",
                  phase, exec_en, instret, exp_instret);
      end
      set_dec(0, 0, 1, 0, 0);
      tick();
      tick();
      n_cmp++;
      if (exec_en !== 1'b1 || pmem_we !== 1'b1) begin
         n_err++;
         $display("FAIL pmem_write: exec_en %b pmem_we %b required 1/1", exec_en, pmem_we);
      end
      tick();
      exp_instret++;
      n_cmp++;
      if (instret !== exp_instret || pmem_we !== 1'b0) begin
         n_err++;
         $display("FAIL pmem_retire: instret %0d pmem_we %b required %0d/0",
                  instret, pmem_we, exp_instret);
      end
   endtask

   task automatic test_load_ack3();
      int req_cnt = 0;
      set_dec(1, 0, 0, 0, 0);
      tick();
      tick();
      n_cmp++;
      if (phase !== 3'd2 || exec_en !== 1'b0 || dmem_req !== 1'b0) begin
         n_err++;
         $display("FAIL load_exec: phase %0d exec_en %b dmem_req %b required 2/0/0",
                  phase, exec_en, dmem_req);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (phase == 3'd3 && dmem_req && !dmem_we) req_cnt++;
         if (i == 2) dmem_ack = 1'b1;
      end
      n_cmp++;
      if (req_cnt !== 3) begin
         n_err++;
         $display("FAIL load_req_cycles: got %0d required 3", req_cnt);
      end
      tick();
      dmem_ack = 1'b0;
      n_cmp++;
      if (phase !== 3'd4 || wb_en !== 1'b1 || dmem_req !== 1'b0) begin
         n_err++;
         $display("FAIL load_wb: phase %0d wb_en %b dmem_req %b required 4/1/0",
                  phase, wb_en, dmem_req);
      end
      tick();
      exp_instret++;
      n_cmp++;
      if (phase !== 3'd0 || instret !== exp_instret) begin
         n_err++;
         $display("FAIL load_retire: phase %0d instret %0d required 0/%0d",
                  phase, instret, exp_instret);
      end
   endtask

   task automatic test_store_ack8();
      int req_cnt = 0;
      set_dec(0, 1, 0, 0, 0);
      tick();
      tick();
      for (int i = 0; i < DMEM_TIMEOUT; i++) begin
         tick();
         if (phase == 3'd3 && dmem_req && dmem_we) req_cnt++;
         if (i == DMEM_TIMEOUT - 1) dmem_ack = 1'b1;
      end
      n_cmp++;
      if (req_cnt !== DMEM_TIMEOUT) begin
         n_err++;
         $display("FAIL store8_req_cycles: got %0d required %0d", req_cnt, DMEM_TIMEOUT);
      end
      tick();
      dmem_ack = 1'b0;
      n_cmp++;
      if (phase !== 3'd4 || wb_en !== 1'b1 || bus_err !== 1'b0) begin
         n_err++;
         $display("FAIL store8_wb: phase %0d wb_en %b bus_err %b required 4/1/0",
                  phase, wb_en, bus_err);
      end
      tick();
      exp_instret++;
      n_cmp++;
      if (instret !== exp_instret || bus_err !== 1'b0) begin
         n_err++;
         $display("FAIL store8_retire: instret %0d bus_err %b required %0d/0",
                  instret, bus_err, exp_instret);
      end
   endtask

   task automatic test_store_timeout();
      int req_cnt = 0;
      set_dec(0, 1, 0, 0, 0);
      tick();
      tick();
      for (int i = 0; i < DMEM_TIMEOUT; i++) begin
         tick();
         if (phase == 3'd3 && dmem_req && dmem_we) req_cnt++;
      end
      n_cmp++;
      if (req_cnt !== DMEM_TIMEOUT) begin
         n_err++;
         $display("FAIL timeout_req_cycles: got %0d required %0d", req_cnt, DMEM_TIMEOUT);
      end
      tick();
      n_cmp++;
      if (phase !== 3'd0 || bus_err !== 1'b1 || wb_en !== 1'b0 || imem_ren !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_abort: phase %0d bus_err %b wb_en %b imem_ren %b required 0/1/0/1",
                  phase, bus_err, wb_en, imem_ren);
      end
      n_cmp++;
      if (instret !== exp_instret) begin
         n_err++;
         $display("FAIL timeout_instret: got %0d required %0d", instret, exp_instret);
      end
   endtask

   task automatic test_irq();
      int base = int_cnt;
      irq = 1'b1;
      set_dec(0, 0, 0, 0, 0);
      repeat (3) begin
         repeat (3) tick();
         exp_instret++;
      end
      n_cmp++;
      if (int_cnt !== base || phase !== 3'd0 || instret !== exp_instret) begin
         n_err++;
         $display("FAIL irq_masked: int pulses %0d phase %0d instret %0d required 0/0/%0d",
                  int_cnt - base, phase, instret, exp_instret);
      end
      set_dec(0, 0, 0, 1, 0);
      repeat (3) tick();
      exp_instret++;
      n_cmp++;
      if (phase !== 3'd5 || int_take !== 1'b1 || ien !== 1'b1) begin
         n_err++;
         $display("FAIL iret_int: phase %0d int_take %b ien %b required 5/1/1",
                  phase, int_take, ien);
      end
      set_dec(0, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if (phase !== 3'd0 || ien !== 1'b0 || int_take !== 1'b0 || int_cnt !== base + 1) begin
         n_err++;
         $display("FAIL int_exit: phase %0d ien %b int_take %b pulses %0d required 0/0/0/1",
                  phase, ien, int_take, int_cnt - base);
      end
      n_cmp++;
      if (instret !== exp_instret) begin
         n_err++;
         $display("FAIL int_instret: got %0d required %0d", instret, exp_instret);
      end
   endtask

   task automatic test_ien_priority();
      irq = 1'b0;
      set_dec(0, 0, 0, 1, 0);
      repeat (3) tick();
      exp_instret++;
      n_cmp++;
      if (ien !== 1'b1 || phase !== 3'd0) begin
         n_err++;
         $display("FAIL iret_noirq: ien %b phase %0d required 1/0", ien, phase);
      end
      irq = 1'b1;
      set_dec(0, 0, 0, 0, 0);
      repeat (3) tick();
      exp_instret++;
      n_cmp++;
      if (phase !== 3'd5 || int_take !== 1'b1) begin
         n_err++;
         $display("FAIL alu_irq_taken: phase %0d int_take %b required 5/1", phase, int_take);
      end
      irq = 1'b0;
      tick();
      set_dec(0, 0, 0, 1, 0);
      repeat (3) tick();
      exp_instret++;
      irq = 1'b1;
      set_dec(0, 0, 0, 1, 1);
      repeat (3) tick();
      exp_instret++;
      n_cmp++;
      if (phase !== 3'd0 || ien !== 1'b0 || int_take !== 1'b0) begin
         n_err++;
         $display("FAIL set_clear_both: phase %0d ien %b int_take %b required 0/0/0",
                  phase, ien, int_take);
      end
      n_cmp++;
      if (instret !== exp_instret) begin
         n_err++;
         $display("FAIL priority_instret: got %0d required %0d", instret, exp_instret);
      end
      irq = 1'b0;
      set_dec(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_mem();
      set_dec(1, 0, 0, 0, 0);
      repeat (4) tick();
      n_cmp++;
      if (phase !== 3'd3 || dmem_req !== 1'b1) begin
         n_err++;
         $display("FAIL mem2_before_rst: phase %0d dmem_req %b required 3/1", phase, dmem_req);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (dmem_req !== 1'b0 || phase !== 3'd0) begin
         n_err++;
         $display("FAIL async_rst_drop: dmem_req %b phase %0d required 0/0", dmem_req, phase);
      end
      tick();
      rst = 1'b0;
      set_dec(0, 0, 0, 0, 0);
      #1;
      n_cmp++;
      if (phase !== 3'd0 || ien !== 1'b0 || bus_err !== 1'b0 || instret !== '0 || imem_ren !== 1'b1) begin
         n_err++;
         $display("FAIL post_rst: phase %0d ien %b bus_err %b instret %0d imem_ren %b required 0/0/0/0/1",
                  phase, ien, bus_err, instret, imem_ren);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_ack3();
      test_store_ack8();
      test_store_timeout();
      test_irq();
      test_ien_priority();
      test_reset_mid_mem();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle phase controller for the 18-bit stack CPU core. It steps each instruction through fetch, decode, execute, data-memory access and write-back, using the control signals produced by the instruction decoder. It owns the interrupt-enable flag, takes interrupts between instructions and counts retired instructions. It sits between the decoder outputs and the register, stack and memory write strobes of the datapath.

Parameters:
DMEM_TIMEOUT, 8, maximum number of MEM-state cycles to wait for dmem_ack before aborting (must be >= 2)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
dec_dmem_ren  in  1  decoder: instruction reads data memory
dec_dmem_wen  in  1  decoder: instruction writes data memory
dec_pmem_wen  in  1  decoder: OR of pmem_wenh and pmem_wenl
dec_set_ien  in  1  decoder: set interrupt enable (IRET)
dec_clear_ien  in  1  decoder: clear interrupt enable
irq  in  1  level-sensitive interrupt request
dmem_ack  in  1  data memory has completed the current request
imem_ren  out  1  program memory read strobe (FETCH)
ir_load  out  1  instruction register capture enable (DECODE)
exec_en  out  1  commit enable for non-memory instructions (EXEC)
pmem_we  out  1  program memory write strobe, qualified commit
dmem_req  out  1  data memory request, held until ack
dmem_we  out  1  request is a write; valid while dmem_req=1
wb_en  out  1  commit enable for memory instructions (WB)
int_take  out  1  one-cycle pulse: datapath loads IP from ISR and pushes the return IP
ien  out  1  interrupt enable flag
bus_err  out  1  sticky flag: data memory timeout occurred
instret  out  CNT_W  retired-instruction count
phase  out  3  current state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 INT=5

Behaviour:
- Reset (asynchronous, takes effect immediately): state=FETCH, ien=0, bus_err=0, instret=0, timeout counter=0. All strobes are 0 while rst=1. In the first cycle after release, phase=0 and imem_ren=1.
- FETCH: imem_ren=1 for 1 cycle, then DECODE.
- DECODE: ir_load=1 for 1 cycle; the IR captures on this edge. Decoder outputs are valid from EXEC onwards. Next state is EXEC.
- EXEC, when dec_dmem_ren|dec_dmem_wen=1: no commit; go to MEM.
- EXEC, otherwise: exec_en=1, and pmem_we=dec_pmem_wen; this is the retire cycle.
- MEM: dmem_req=1 and dmem_we=dec_dmem_wen for every MEM cycle. The timeout counter increments each MEM cycle without ack.
- MEM, dmem_ack=1: go to WB and clear the counter.
- MEM, dmem_ack=0 on the DMEM_TIMEOUT-th cycle: set bus_err, clear the counter, go to FETCH. There is no commit and instret is not incremented.
- MEM, ack and timeout in the same cycle: ack wins; no bus_err.
- WB: wb_en=1 for 1 cycle; this is the retire cycle.
- Retire cycle (EXEC without memory, or WB):
  - instret increments by 1 and wraps modulo 2^CNT_W.
  - new_ien = dec_clear_ien ? 0 : (dec_set_ien ? 1 : ien); clear wins when both are set. ien takes new_ien at the edge.
  - Next state is INT if irq && new_ien, else FETCH.
- INT: int_take=1 for 1 cycle, ien cleared, then FETCH. irq is not sampled in INT. INT does not increment instret.
- Interrupts are recognised only at retire cycles, never mid-instruction. irq with ien=0 is ignored and not latched.
- At most one of imem_ren, ir_load, exec_en, dmem_req, wb_en, int_take is high in any cycle.
- bus_err clears only on reset.
- Latency: non-memory instruction = 3 cycles. Memory instruction = 4 + (ack wait) cycles; an ack in the first MEM cycle gives 5 cycles total.

Test Plan:
- Release reset, ALU op, irq=0: phase 0,1,2,0; exec_en high in cycle 3 only; instret=1 after that cycle.
- Load with dmem_ack asserted in the 3rd MEM cycle: dmem_req high for exactly 3 cycles with dmem_we=0; wb_en pulses next cycle; instret +1.
- DMEM_TIMEOUT=8, store, ack never asserted: 8 MEM cycles with dmem_we=1, then bus_err=1, phase=0, no wb_en, instret unchanged. Same test with ack arriving in the 8th cycle: WB taken, bus_err=0.
- irq=1 with ien=0 through 3 ALU ops: int_take never asserted. Then an IRET-type instruction (dec_set_ien=1) retires with irq=1: next phase=5, int_take pulses once, ien=0, then FETCH.
- dec_set_ien=1 and dec_clear_ien=1 together at retire: ien=0 afterwards; no INT even with irq=1.
- Assert rst during the 2nd MEM cycle: dmem_req drops in the same cycle; after release phase=0 and ien, bus_err and instret are all 0.
